// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel 2-FF synchroniser, debounce, left/right
// conflict suppression and a one-cycle move pulse with hold-to-repeat.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic left_raw,
    input  logic right_raw,
    output logic left,
    output logic right,
    output logic left_level,
    output logic right_level,
    output logic conflict
);

    // Per-channel repeat FSM state; r_state[0] is left, r_state[1] is right.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RP_LOAD   = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       w_raw;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_level;
    logic [1:0]       w_level_next;
    logic [CNT_W-1:0] r_db_cnt [2];
    logic [CNT_W-1:0] w_db_cnt_next [2];
    logic             r_conflict;

    logic [1:0]       w_act;
    logic [1:0]       r_act_prev;
    state_t           r_state [2];
    state_t           w_state_next [2];
    logic [CNT_W-1:0] r_rep_cnt [2];
    logic [CNT_W-1:0] w_rep_cnt_next [2];
    logic [1:0]       r_pulse;
    logic [1:0]       w_pulse_next;

    assign w_raw = {right_raw, left_raw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only survives while the synchronised input disagrees with
    // the level; any agreeing cycle restarts the qualification window.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_level_next[i]  = r_level[i];
            w_db_cnt_next[i] = '0;
            if (r_sync2[i] != r_level[i]) begin
                if (r_db_cnt[i] == DB_LAST) begin
                    w_level_next[i] = r_sync2[i];
                end else begin
                    w_db_cnt_next[i] = r_db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level    <= '0;
            r_conflict <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_level    <= w_level_next;
            r_conflict <= w_level_next[0] & w_level_next[1];
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= w_db_cnt_next[i];
            end
        end
    end

    // A channel is active only when it is the sole key held and play is on.
    assign w_act[0] = r_level[0] & ~r_level[1] & enable;
    assign w_act[1] = r_level[1] & ~r_level[0] & enable;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_state_next[i]   = r_state[i];
            w_rep_cnt_next[i] = r_rep_cnt[i];
            w_pulse_next[i]   = 1'b0;
            if (!w_act[i]) begin
                w_state_next[i]   = IDLE;
                w_rep_cnt_next[i] = '0;
            end else begin
                case (r_state[i])
                    IDLE: begin
                        if (!r_act_prev[i]) begin
                            w_pulse_next[i]   = 1'b1;
                            w_rep_cnt_next[i] = RD_LOAD;
                            w_state_next[i]   = FIRST;
                        end
                    end
                    FIRST, REPEAT: begin
                        if (r_rep_cnt[i] == CNT_ONE) begin
                            w_pulse_next[i]   = 1'b1;
                            w_rep_cnt_next[i] = RP_LOAD;
                            w_state_next[i]   = REPEAT;
                        end else begin
                            w_rep_cnt_next[i] = r_rep_cnt[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        w_state_next[i]   = IDLE;
                        w_rep_cnt_next[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act_prev <= '0;
            r_pulse    <= '0;
            for (int i = 0; i < 2; i++) begin
                r_state[i]   <= IDLE;
                r_rep_cnt[i] <= '0;
            end
        end else begin
            r_act_prev <= w_act;
            r_pulse    <= w_pulse_next;
            for (int i = 0; i < 2; i++) begin
                r_state[i]   <= w_state_next[i];
                r_rep_cnt[i] <= w_rep_cnt_next[i];
            end
        end
    end

    // Gating with enable kills a pulse registered just before play stopped.
    assign left        = r_pulse[0] & enable;
    assign right       = r_pulse[1] & enable;
    assign left_level  = r_level[0];
    assign right_level = r_level[1];
    assign conflict    = r_conflict;

endmodule
